// File: rtl/ft_rf_recovery.sv
// Lockstep recovery sequencer: on a comparator mismatch, halt both cores, replay the golden
// register file into them over a shared write port, then restore the checkpointed PC.
module ft_rf_recovery #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 32,
  parameter int HALT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  error_i,
  input  logic [DATA_WIDTH-1:0] pc_checkpoint_i,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  halt_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  pc_restore_valid_o,
  output logic [DATA_WIDTH-1:0] pc_restore_o,
  output logic                  done_o,
  output logic [7:0]            recovery_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HALT,
    S_RESTORE,
    S_RESUME
  } state_t;

  // One extra index bit so NUM_REGS == 2**ADDR_WIDTH still reaches its terminal value.
  localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH + 1)'(NUM_REGS - 1);
  localparam logic [3:0]          HALT_LAST = 4'(HALT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_idx;
  logic [3:0]            r_halt_cnt;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [7:0]            r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx      <= (ADDR_WIDTH + 1)'(1);
      r_halt_cnt <= 4'd0;
      r_pc       <= '0;
      r_count    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (error_i) begin
            r_pc       <= pc_checkpoint_i;
            r_halt_cnt <= 4'd0;
            if (r_count != 8'hFF) begin
              r_count <= r_count + 8'd1;
            end
          end
        end
        S_HALT: begin
          r_halt_cnt <= r_halt_cnt + 4'd1;
          if (r_halt_cnt == HALT_LAST) begin
            r_idx <= (ADDR_WIDTH + 1)'(1);
          end
        end
        S_RESTORE: r_idx <= r_idx + (ADDR_WIDTH + 1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    halt_o             = 1'b0;
    rf_we_o            = 1'b0;
    rf_raddr_o         = '0;
    rf_waddr_o         = '0;
    rf_wdata_o         = '0;
    pc_restore_valid_o = 1'b0;
    done_o             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (error_i) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        halt_o = 1'b1;
        if (r_halt_cnt == HALT_LAST) begin
          w_state_nxt = S_RESTORE;
        end
      end
      S_RESTORE: begin
        // Golden read data passes straight through to the write port in the same cycle.
        halt_o     = 1'b1;
        rf_we_o    = 1'b1;
        rf_raddr_o = r_idx[ADDR_WIDTH-1:0];
        rf_waddr_o = r_idx[ADDR_WIDTH-1:0];
        rf_wdata_o = rf_rdata_i;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_RESUME;
        end
      end
      S_RESUME: begin
        halt_o             = 1'b1;
        pc_restore_valid_o = 1'b1;
        done_o             = 1'b1;
        w_state_nxt        = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pc_restore_o     = r_pc;
  assign recovery_count_o = r_count;

endmodule
